// File: rtl/rssb_pkg.sv
// Shared types and helpers for the RSSB one-instruction core sequencer.
package rssb_pkg;

  localparam int WIDTH_DEF = 8;
  localparam logic [7:0] HALT_OP_DEF = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RD,
    EXEC,
    WR,
    HALT
  } rssb_state_e;

  // Signed less-than from sign bits and the unsigned compare; width-independent.
  function automatic logic signed_lt(input logic a_msb, input logic b_msb, input logic unsigned_lt);
    return (a_msb != b_msb) ? a_msb : unsigned_lt;
  endfunction

endpackage

// File: rtl/rssb_alu.sv
// Reverse-subtract datapath: diff = rdata - acc (wrapping), borrow = signed rdata < acc.
module rssb_alu
  import rssb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  assign diff = rdata - acc;

  // Borrow is a true signed compare, not the sign bit of the wrapped difference.
  assign borrow = signed_lt(rdata[WIDTH-1], acc[WIDTH-1], rdata < acc);

endmodule

// File: rtl/rssb_seq_ctrl.sv
// RSSB sequencer: FETCH -> RD -> EXEC -> WR per instruction, owns pc/acc/run status.
// Optional retire counter and last_skip flag are built when RSSB_RETIRE_CNT_EN is defined.
module rssb_seq_ctrl
  import rssb_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0] HALT_OP  = WIDTH'(HALT_OP_DEF),
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             halted
`ifdef RSSB_RETIRE_CNT_EN
  ,
  output logic [31:0]      retired,
  output logic             last_skip
`endif
);

  rssb_state_e state, state_next;

  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] rdata_q;
  logic             borrow_q;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             idle_like;

  rssb_alu #(.WIDTH(WIDTH)) u_alu (
    .rdata (rdata_q),
    .acc   (acc),
    .diff  (diff),
    .borrow(borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, HALT: if (start) state_next = FETCH;
      FETCH:      state_next = (rom_data == HALT_OP) ? HALT : RD;
      RD:         if (mem_ready) state_next = EXEC;
      EXEC:       state_next = WR;
      WR:         if (mem_ready) state_next = FETCH;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= PC_RESET;
      acc       <= '0;
      opnd      <= '0;
      rdata_q   <= '0;
      borrow_q  <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc  <= PC_RESET;
            acc <= '0;
          end
        end
        FETCH: opnd <= rom_data;
        RD:    if (mem_ready) rdata_q <= mem_rdata;
        EXEC: begin
          acc       <= diff;
          mem_wdata <= diff;
          borrow_q  <= borrow;
        end
        WR:    if (mem_ready) pc <= pc + (borrow_q ? WIDTH'(2) : WIDTH'(1));
        default: ;
      endcase
    end
  end

  // Request strobes decode straight from state so reset drops them at once.
  assign idle_like = (state == IDLE) || (state == HALT);
  assign rom_addr  = pc;
  assign mem_req   = (state == RD) || (state == WR);
  assign mem_we    = (state == WR);
  assign mem_addr  = opnd;
  assign busy      = !idle_like;
  assign halted    = (state == HALT);

`ifdef RSSB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired   <= '0;
      last_skip <= 1'b0;
    end else if (idle_like && start) begin
      retired <= '0;
    end else if (state == WR && mem_ready) begin
      if (retired != 32'hFFFF_FFFF) retired <= retired + 32'd1;
      last_skip <= borrow_q;
    end
  end
`endif

endmodule

// File: tb/tb_rssb_seq_ctrl.sv
// Directed self-checking bench for rssb_seq_ctrl with a ROM/RAM model and programmable wait states.
module tb_rssb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] rom_addr, rom_data;
  logic       mem_req, mem_we, mem_ready;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] pc, acc;
  logic       busy, halted;
`ifdef RSSB_RETIRE_CNT_EN
  logic [31:0] retired;
  logic        last_skip;
`endif

  logic [7:0] rom [256];
  logic [7:0] ram [256];
  int total = 0;
  int bad = 0;
  int wait_n = 0;
  int wcnt = 0;

  always #5 clk = ~clk;

  rssb_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc       (pc),
    .acc      (acc),
    .busy     (busy),
    .halted   (halted)
`ifdef RSSB_RETIRE_CNT_EN
    ,
    .retired  (retired),
    .last_skip(last_skip)
`endif
  );

  // Memory model: combinational read, write on a completed transfer, wait_n stall cycles per request.
  assign rom_data  = rom[rom_addr];
  assign mem_rdata = ram[mem_addr];
  assign mem_ready = (wcnt >= wait_n);

  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s);
    start = s;
    tick();
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'h20;
      ram[i] = 8'h00;
    end
    rom[0] = 8'h05; ram[5] = 8'h03;
    rom[1] = 8'h07; ram[7] = 8'h01;
    rom[3] = 8'hFF;

    #3;
    checkOutput("rst_pc", pc, 8'h00);
    checkOutput("rst_acc", acc, 8'h00);
    checkOutput("rst_req", mem_req, 1'b0);
    checkOutput("rst_we", mem_we, 1'b0);
    checkOutput("rst_wdata", mem_wdata, 8'h00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);

    #10 rst_n = 1'b1;
    tick();

    // Basic op, zero-wait: ROM[0]=5, RAM[5]=3
    applyStimulus(1'b1);
    checkOutput("fetch_busy", busy, 1'b1);
    checkOutput("fetch_romaddr", rom_addr, 8'h00);
    tick();
    checkOutput("rd_req", mem_req, 1'b1);
    checkOutput("rd_we", mem_we, 1'b0);
    checkOutput("rd_addr", mem_addr, 8'h05);
    tick();
    checkOutput("exec_req", mem_req, 1'b0);
    tick();
    checkOutput("wr_we", mem_we, 1'b1);
    checkOutput("wr_wdata", mem_wdata, 8'h03);
    checkOutput("wr_acc", acc, 8'h03);
    tick();
    checkOutput("op1_pc", pc, 8'h01);
    checkOutput("op1_ram", ram[5], 8'h03);

    // Skip: 1 - 3 = FE with borrow
    repeat (4) tick();
    checkOutput("op2_acc", acc, 8'hFE);
    checkOutput("op2_ram", ram[7], 8'hFE);
    checkOutput("op2_pc", pc, 8'h03);

    // Halt on ROM[3]=FF
    tick();
    checkOutput("halt_halted", halted, 1'b1);
    checkOutput("halt_busy", busy, 1'b0);
    repeat (3) tick();
    checkOutput("halt_pc", pc, 8'h03);
    checkOutput("halt_req", mem_req, 1'b0);

    // Restart with 3 wait cycles on each transfer
    wait_n = 3;
    applyStimulus(1'b1);
    checkOutput("restart_pc", pc, 8'h00);
    checkOutput("restart_acc", acc, 8'h00);
    tick();
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("wrd_req%0d", k), mem_req, 1'b1);
      checkOutput($sformatf("wrd_we%0d", k), mem_we, 1'b0);
      checkOutput($sformatf("wrd_addr%0d", k), mem_addr, 8'h05);
      tick();
    end
    checkOutput("wexec_req", mem_req, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("wwr_req%0d", k), mem_req, 1'b1);
      checkOutput($sformatf("wwr_we%0d", k), mem_we, 1'b1);
      checkOutput($sformatf("wwr_addr%0d", k), mem_addr, 8'h05);
      checkOutput($sformatf("wwr_wdata%0d", k), mem_wdata, 8'h03);
      checkOutput($sformatf("wwr_pc%0d", k), pc, 8'h00);
      tick();
    end
    checkOutput("w1_pc", pc, 8'h01);
    checkOutput("w1_acc", acc, 8'h03);
    checkOutput("w1_ram", ram[5], 8'h03);

    // Second waited op: FE - 03 = FB with borrow; start pulsed mid-RD must be ignored
    tick();
    checkOutput("w2_rd_addr", mem_addr, 8'h07);
    applyStimulus(1'b1);
    checkOutput("ign_pc", pc, 8'h01);
    checkOutput("ign_acc", acc, 8'h03);
    checkOutput("ign_busy", busy, 1'b1);
    checkOutput("ign_req", mem_req, 1'b1);
    checkOutput("ign_addr", mem_addr, 8'h07);
    repeat (8) tick();
    checkOutput("w2_acc", acc, 8'hFB);
    checkOutput("w2_ram", ram[7], 8'hFB);
    checkOutput("w2_pc", pc, 8'h03);
    tick();
    checkOutput("w2_halted", halted, 1'b1);

    // Boundary: 80 - 01 = 7F must still skip (signed -128 < 1)
    wait_n = 0;
    rom[0] = 8'h10; ram[8'h10] = 8'h01;
    rom[1] = 8'h11; ram[8'h11] = 8'h80;
    rom[3] = 8'h20;
    applyStimulus(1'b1);
    repeat (4) tick();
    checkOutput("bnd1_acc", acc, 8'h01);
    checkOutput("bnd1_pc", pc, 8'h01);
    repeat (4) tick();
    checkOutput("bnd2_acc", acc, 8'h7F);
    checkOutput("bnd2_ram", ram[8'h11], 8'h7F);
    checkOutput("bnd2_pc", pc, 8'h03);

    // pc wrap FF -> 00 without borrow (RAM[20] settles to zero)
    n = 0;
    while (pc != 8'hFF && n < 3000) begin
      tick();
      n++;
    end
    checkOutput("reach_ff", pc, 8'hFF);
    repeat (4) tick();
    checkOutput("wrap_pc", pc, 8'h00);
    checkOutput("wrap_acc", acc, 8'h00);

    // Asynchronous reset while waiting in WR
    wait_n = 3;
    n = 0;
    while (!mem_we && n < 50) begin
      tick();
      n++;
    end
    checkOutput("reach_wr", mem_we, 1'b1);
    tick();
    checkOutput("pre_rst_acc", acc, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_req", mem_req, 1'b0);
    checkOutput("arst_we", mem_we, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_halted", halted, 1'b0);
    checkOutput("arst_pc", pc, 8'h00);
    checkOutput("arst_acc", acc, 8'h00);
    checkOutput("arst_wdata", mem_wdata, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rssb_seq_ctrl.md
Name: rssb_seq_ctrl

Overview:
- Sequencer for the RSSB (reverse-subtract-and-skip-if-borrow) one-instruction core.
- Each step fetches an operand address from the combinational program ROM (WIDTH-bit address in, signed WIDTH-bit word out).
- It then reads that data-memory word, computes mem-acc, writes the result back to memory and to acc, and advances pc by 1, or by 2 on borrow.
- Sits between the program ROM and a handshaked data RAM. Owns pc, acc and run/halt status.

Parameters:
- WIDTH, 8, address and data width in bits.
- HALT_OP, 8'hFF, operand value that stops execution when fetched.
- PC_RESET, 8'h00, pc value loaded on reset and on start.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin execution from PC_RESET with acc=0.
- rom_addr  out  WIDTH  program ROM address; always equals pc.
- rom_data  in  WIDTH  signed operand from ROM (combinational).
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  WIDTH  data-memory address; equals latched operand.
- mem_wdata  out  WIDTH  write data.
- mem_rdata  in  WIDTH  read data; valid in the cycle mem_req&&mem_ready&&!mem_we.
- mem_ready  in  1  transfer completes in any cycle with mem_req&&mem_ready.
- pc  out  WIDTH  program counter.
- acc  out  WIDTH  accumulator (signed).
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=PC_RESET, acc=0, operand register=0.
  - mem_req=0, mem_we=0, mem_wdata=0, busy=0, halted=0.
- States and transitions:
  - IDLE: on start -> FETCH with pc=PC_RESET, acc=0.
  - FETCH (1 cycle): latch opnd=rom_data. If rom_data==HALT_OP -> HALT with pc unchanged; else -> RD.
  - RD: mem_req=1, mem_we=0, mem_addr=opnd. Hold all outputs stable until mem_ready. On completion latch rdata -> EXEC.
  - EXEC (1 cycle): diff = rdata - acc, modulo 2^WIDTH. borrow = ($signed(rdata) < $signed(acc)), a true signed compare, not the sign of the wrapped diff. Set acc=diff, mem_wdata=diff -> WR.
  - WR: mem_req=1, mem_we=1, mem_addr=opnd. Hold until mem_ready. On completion pc += borrow ? 2 : 1, modulo 2^WIDTH -> FETCH.
  - HALT: outputs frozen; start -> FETCH with pc=PC_RESET, acc=0.
- Latency: 4 cycles per instruction with zero-wait memory; each memory wait cycle adds 1.
- mem_req is deasserted in FETCH and EXEC; there are no back-to-back requests across states.
- start is ignored while busy.
- pc wraps: 8'hFF+1=8'h00, 8'hFE+2=8'h00, 8'hFF+2=8'h01.
- Borrow at the extremes: rdata=8'h80 (-128), acc=8'h01 gives diff=8'h7F and borrow=1 (skip).
- Reset mid-transaction: mem_req drops immediately (asynchronous); the interrupted write is the RAM's concern.
- mem_ready outside mem_req is ignored.

Optional Feature:
- Macro: RSSB_RETIRE_CNT_EN.
- When defined:
  - Adds output retired [31:0], counting completed WR transactions. Saturates at 32'hFFFF_FFFF.
  - Cleared on reset and on an accepted start.
  - Adds output last_skip (1), the borrow flag of the last retired instruction, reset 0.
- When undefined: neither port exists and no counter logic is built.

Decomposition:
- Package rssb_pkg holds:
  - state enum rssb_state_e {IDLE, FETCH, RD, EXEC, WR, HALT};
  - localparam WIDTH_DEF=8, HALT_OP_DEF=8'hFF;
  - a function for the signed borrow compare.
- One natural sub-module, rssb_alu: combinational diff/borrow from rdata and acc, shared with the verification reference model.
- The FSM and registers stay in rssb_seq_ctrl.

Test Plan:
- Basic op: ROM[0]=5, RAM[5]=3, zero-wait memory, start -> after 4 cycles acc=3, RAM[5]=3, pc=1.
- Skip: continue with ROM[1]=7, RAM[7]=1, acc=3 -> diff=8'hFE, RAM[7]=8'hFE, acc=8'hFE, pc=3.
- Halt: ROM[3]=8'hFF -> HALT with halted=1, busy=0, pc=3 held. A later start restarts at pc=0 with acc=0.
- Wait states: mem_ready low for 3 cycles in both RD and WR -> mem_req/mem_we/mem_addr/mem_wdata stable throughout; instruction takes 10 cycles; results identical.
- Boundary: rdata=8'h80, acc=8'h01 -> diff=8'h7F, skip. Separately pc=8'hFF without borrow -> pc=8'h00.
- Reset during WR wait -> all outputs return to reset values asynchronously. start is ignored while busy, checked mid-RD.
